// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, state encoding, reset PC.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, F/D buffer,
// delayed-slot redirects and immediate flushes that orphan in-flight responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            d_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            accept_c;

  // req_q is low in the reset cycle, so acceptance must be qualified by it
  assign accept_c = (state_q == IF_FETCH) && req_q && imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;

    if (redirect_valid) begin
      pend_d = 1'b1;
      tgt_d  = redirect_pc;
    end

    case (state_q)
      IF_FETCH: if (accept_c) state_d = IF_WAIT;
      IF_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = IF_HOLD;
        end
      end
      IF_HOLD: begin
        // A redirect arriving on the accept cycle targets the slot after this one
        if (!d_stall) begin
          if (redirect_valid) pc_d = redirect_pc;
          else if (pend_q)    pc_d = tgt_q;
          else                pc_d = pc_q + XLEN'(4);
          pend_d  = 1'b0;
          state_d = IF_FETCH;
        end
      end
      IF_DROP: if (imem_rvalid) state_d = IF_FETCH;
      default: state_d = IF_FETCH;
    endcase

    // Flush overrides everything above; an accepted or pending request becomes an orphan
    if (flush_valid) begin
      pc_d    = flush_pc;
      pend_d  = 1'b0;
      instr_d = instr_q;
      case (state_q)
        IF_FETCH: state_d = accept_c ? IF_DROP : IF_FETCH;
        IF_WAIT:  state_d = imem_rvalid ? IF_FETCH : IF_DROP;
        IF_HOLD:  state_d = IF_FETCH;
        IF_DROP:  state_d = imem_rvalid ? IF_FETCH : IF_DROP;
        default:  state_d = IF_FETCH;
      endcase
    end

    valid_d = (state_d == IF_HOLD);
    req_d   = (state_d == IF_FETCH);
  end

  assign imem_req  = req_q;
  assign imem_addr = {pc_q[XLEN-1:2], 2'b00};
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a latency-programmable imem responder plus
// cycle-exact scenario tasks with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        d_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_cmp = 0;
  int n_err = 0;
  int mem_k = 1;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .d_stall        (d_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  // Memory word at address a is 32'hA000_0000 ^ a; responses keep coming even across reset/flush
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  always begin
    logic acc;
    logic [31:0] a;
    @(posedge clk);
    acc = imem_req && imem_ready;
    a   = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_0000 ^ rsp_addr;
      end
    end
    if (acc) begin
      rsp_addr = a;
      if (mem_k <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_0000 ^ a;
      end else begin
        rsp_cnt = mem_k - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0000_3000) begin n_err++; $display("FAIL rst_pc got %h exp 00003000", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 00000000", if_instr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'h0000_3000 + 32'(4 * i);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL seq_req%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, a); end
      tick();
      n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait%0d got req %b valid %b exp 0/0", i, imem_req, if_valid); end
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (32'hA000_0000 ^ a)) begin
        n_err++; $display("FAIL seq_hold%0d got %b/%h/%h exp 1/%h/%h", i, if_valid, if_pc, if_instr, a, 32'hA000_0000 ^ a);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    n_cmp++; if (imem_addr !== 32'h0000_300C) begin n_err++; $display("FAIL stall_pre got %h exp 0000300c", imem_addr); end
    tick();
    d_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_300C || if_instr !== 32'hA000_300C || imem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got %b/%h/%h req %b exp 1/0000300c/a000300c req 0", i, if_valid, if_pc, if_instr, imem_req);
      end
    end
    d_stall = 1'b0;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3010) begin n_err++; $display("FAIL stall_release got %b/%h exp 1/00003010", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3010) begin n_err++; $display("FAIL redir_slot got %b/%h exp 1/00003010", if_valid, if_pc); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3100) begin n_err++; $display("FAIL redir_target got %b/%h exp 1/00003100", imem_req, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3300;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3100 || if_instr !== 32'hA000_3100) begin
      n_err++; $display("FAIL redir_slot2 got %b/%h/%h exp 1/00003100/a0003100", if_valid, if_pc, if_instr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3400;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3400) begin n_err++; $display("FAIL redir_latest got %b/%h exp 1/00003400", imem_req, imem_addr); end
  endtask

  task automatic test_flush_wait();
    mem_k = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3500;
    tick();
    redirect_valid = 1'b0;
    flush_valid = 1'b1; flush_pc = 32'h0000_4180;
    tick();
    flush_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL flushw_drop got valid %b req %b exp 0/0", if_valid, imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL flushw_orphan got req %b valid %b exp 0/0", imem_req, if_valid); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4180) begin n_err++; $display("FAIL flushw_refetch got %b/%h exp 1/00004180", imem_req, imem_addr); end
    repeat (4) tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_4180 || if_instr !== 32'hA000_4180) begin
      n_err++; $display("FAIL flushw_hold got %b/%h/%h exp 1/00004180/a0004180", if_valid, if_pc, if_instr);
    end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4184) begin n_err++; $display("FAIL flushw_pend_cleared got %b/%h exp 1/00004184", imem_req, imem_addr); end
  endtask

  task automatic test_flush_accept();
    mem_k = 1;
    flush_valid = 1'b1; flush_pc = 32'h0000_4200;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4300;
    tick();
    flush_valid = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL flusha_drop got req %b valid %b exp 0/0", imem_req, if_valid); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4200) begin n_err++; $display("FAIL flusha_wins got %b/%h exp 1/00004200", imem_req, imem_addr); end
    repeat (2) tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_4200 || if_instr !== 32'hA000_4200) begin
      n_err++; $display("FAIL flusha_hold got %b/%h/%h exp 1/00004200/a0004200", if_valid, if_pc, if_instr);
    end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4204) begin n_err++; $display("FAIL flusha_seq got %b/%h exp 1/00004204", imem_req, imem_addr); end
    imem_ready = 1'b0;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4204) begin n_err++; $display("FAIL fetch_stable got %b/%h exp 1/00004204", imem_req, imem_addr); end
    flush_valid = 1'b1; flush_pc = 32'h0000_5000;
    tick();
    flush_valid = 1'b0; imem_ready = 1'b1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_5000) begin n_err++; $display("FAIL flushf_next got %b/%h exp 1/00005000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    mem_k = 3;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_k = 1;
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0000_3000) begin
      n_err++; $display("FAIL rstw_state got %b/%b/%h exp 0/0/00003000", if_valid, imem_req, if_pc);
    end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL rstw_req got %b/%h exp 1/00003000", imem_req, imem_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rstw_late_rvalid got valid %b exp 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3000 || if_instr !== 32'hA000_3000) begin
      n_err++; $display("FAIL rstw_hold got %b/%h/%h exp 1/00003000/a0003000", if_valid, if_pc, if_instr);
    end
    d_stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; d_stall = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0000_3000 || if_instr !== 32'h0) begin
      n_err++; $display("FAIL rsth_state got %b/%b/%h/%h exp 0/0/00003000/00000000", if_valid, imem_req, if_pc, if_instr);
    end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL rsth_req got %b/%h exp 1/00003000", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    flush_valid = 1'b0; flush_pc = '0; imem_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; d_stall = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush_wait();
    test_flush_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined MIPS core. It owns the architectural fetch PC and issues one request at a time to a variable-latency instruction memory. It buffers the returned word for the F/D pipeline register and applies D-stage branch/jump targets after the delay slot. It also applies immediate flush redirects (exception/eret), discarding any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  one-cycle pulse: D-stage branch taken or jump resolved
- redirect_pc  in  32  target from the next-PC logic
- flush_valid  in  1  one-cycle pulse: abandon current stream now
- flush_pc  in  32  handler / EPC target
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of the request, bits [1:0] always 0
- imem_ready  in  1  memory accepts the request this cycle when high with imem_req
- imem_rvalid  in  1  response strobe, at least 1 cycle after acceptance
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- d_stall  in  1  hazard unit holds F/D; the held instruction is not consumed
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  32  buffered instruction
- if_pc  out  32  address of if_instr

## Operation
- Registers:
  - state
  - pc: address being fetched/held
  - instr buffer
  - redir_pend, redir_tgt
- States:
  - FETCH: imem_req=1, imem_addr={pc[31:2],2'b00}. imem_ready → WAIT.
  - WAIT: imem_req=0. imem_rvalid → capture imem_rdata, go to HOLD.
  - HOLD: if_valid=1, if_pc=pc. When !d_stall (accept):
    - pc ← redir_pend ? redir_tgt : pc+4, modulo 2^32
    - clear redir_pend
    - go to FETCH
  - DROP: awaiting an orphaned response. imem_rvalid → discard, go to FETCH.
- Redirect (delay slot preserved):
  - redirect_valid sets redir_pend and redir_tgt=redirect_pc.
  - The instruction currently fetched/held (the delay slot) still completes.
  - If redirect_valid coincides with acceptance in HOLD, the new target is used directly.
  - A second redirect while pending: latest wins.
- Flush, effective in any state:
  - pc ← flush_pc, redir_pend ← 0, buffer invalidated.
  - FETCH without acceptance that cycle → FETCH (new address next cycle).
  - FETCH with imem_ready the same cycle → DROP.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid → data discarded, go to FETCH.
  - HOLD → FETCH.
  - DROP → stays DROP.
- Priority: reset > flush > redirect > sequential.
- At most one outstanding imem request. imem_rvalid outside WAIT/DROP is ignored.

## Timing
- Reset (synchronous):
  - state=FETCH, pc=RESET_PC, redir_pend=0
  - imem_req=0 and if_valid=0 during the reset cycle
  - if_instr=0, if_pc=RESET_PC
- imem_req is asserted from the first cycle after reset deasserts.
- Latency:
  - acceptance at cycle N, rvalid at N+k → if_valid high at N+k+1
  - minimum issue interval per instruction is 3 cycles at k=1
- if_valid, if_instr and if_pc are registered and stable while d_stall=1.
- imem_req/imem_addr are stable from assertion until accepted, unless a flush changes the address.
- Flush in cycle T: if_valid=0 from T+1. A new request to flush_pc is issued at T+1 (FETCH case) or the cycle after the orphan response (DROP case).

## Structure
- Shared package/const.v:
  - state encodings `IF_FETCH, `IF_WAIT, `IF_HOLD, `IF_DROP (2-bit)
  - `PC_RESET 32'h0000_3000, also the default for RESET_PC
- No sub-module. The next-PC arithmetic beyond pc+4 stays in the existing D-stage next-PC logic, which feeds redirect_pc.

## Test plan
- Reset, imem_ready=1, k=1 → requests to 0x3000, 0x3004, 0x3008. if_pc follows with if_valid every 3rd cycle, instructions in order.
- Hold d_stall=1 for 4 cycles in HOLD at 0x3004 → if_instr/if_pc unchanged, imem_req=0. Release → fetch 0x3008.
- redirect_valid with redirect_pc=0x3100 while WAIT for 0x3008 → 0x3008 delivered (delay slot), next request 0x3100. Same pulse during HOLD acceptance → next request 0x3100.
- flush_valid with flush_pc=0x4180 during WAIT, k=3 → if_valid=0, the stale response is discarded, next request 0x4180, pending redirect cleared.
- flush_valid the same cycle as imem_ready → DROP. Response ignored, then fetch of flush_pc. Flush and redirect simultaneous → flush_pc wins.
- Reset asserted in WAIT and in HOLD → next cycle state=FETCH, pc=0x3000, if_valid=0. A late rvalid from before reset is ignored.
